// File: rtl/vga_fb_reader_if.sv
// Halfword read port between the framebuffer reader and external memory.
// The master holds mem_rd/mem_addr until the slave answers with a one-cycle mem_ready.
interface vga_fb_reader_if #(
  parameter int MEM_ADDR_WIDTH = 22
);
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_rd;
  logic [15:0]               mem_rdata;
  logic                      mem_ready;

  modport master (output mem_addr, output mem_rd, input mem_rdata, input mem_ready);
  modport slave  (input mem_addr, input mem_rd, output mem_rdata, output mem_ready);
endinterface

// File: rtl/vga_fb_reader.sv
// Serves 48-bit display blocks as three 16-bit memory beats and owns the
// double-buffered frame base that is swapped only on the display's frame wrap.
module vga_fb_reader #(
  parameter int                    ADDR_WIDTH     = 20,
  parameter int                    MEM_ADDR_WIDTH = 22,
  parameter logic [ADDR_WIDTH-1:0] DEFAULT_BASE   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  input  logic                  vga_sel,
  output logic [47:0]           vga_data,
  output logic                  vga_valid,
  output logic [ADDR_WIDTH-1:0] vga_offset,
  input  logic                  vga_offset_sel,
  input  logic                  cpu_base_we,
  input  logic [ADDR_WIDTH-1:0] cpu_base_din,
  output logic                  cpu_base_pending,
  vga_fb_reader_if.master       mem
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic                      mem_rd_reg, mem_rd_next;
  logic                      valid_reg, valid_next;
  logic [47:0]               data_reg, data_next;
  logic [ADDR_WIDTH-1:0]     cur_base_reg, pend_base_reg;
  logic                      pending_reg;

  logic [MEM_ADDR_WIDTH-1:0] addr_ext, addr_x3;

  // Block index to halfword address: three halfwords per block.
  assign addr_ext = MEM_ADDR_WIDTH'(vga_addr);
  assign addr_x3  = (addr_ext << 1) + addr_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      mem_addr_reg <= '0;
      mem_rd_reg   <= 1'b0;
      valid_reg    <= 1'b0;
      data_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      mem_addr_reg <= mem_addr_next;
      mem_rd_reg   <= mem_rd_next;
      valid_reg    <= valid_next;
      data_reg     <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (vga_sel) state_next = RD0;
      RD0:     if (mem.mem_ready) state_next = RD1;
      RD1:     if (mem.mem_ready) state_next = RD2;
      RD2:     if (mem.mem_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered: the values computed here appear the cycle after.
  always_comb begin
    mem_addr_next = mem_addr_reg;
    mem_rd_next   = mem_rd_reg;
    valid_next    = 1'b0;
    data_next     = data_reg;
    case (state_reg)
      IDLE: begin
        if (vga_sel) begin
          mem_rd_next   = 1'b1;
          mem_addr_next = addr_x3;
        end
      end
      RD0: begin
        if (mem.mem_ready) begin
          data_next[15:0] = mem.mem_rdata;
          mem_addr_next   = mem_addr_reg + MEM_ADDR_WIDTH'(1);
        end
      end
      RD1: begin
        if (mem.mem_ready) begin
          data_next[31:16] = mem.mem_rdata;
          mem_addr_next    = mem_addr_reg + MEM_ADDR_WIDTH'(1);
        end
      end
      RD2: begin
        if (mem.mem_ready) begin
          data_next[47:32] = mem.mem_rdata;
          mem_rd_next      = 1'b0;
          valid_next       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem.mem_addr = mem_addr_reg;
  assign mem.mem_rd   = mem_rd_reg;
  assign vga_data     = data_reg;
  assign vga_valid    = valid_reg;

  // Combinational so the display latches the new base in the wrap cycle itself.
  assign vga_offset       = pending_reg ? pend_base_reg : cur_base_reg;
  assign cpu_base_pending = pending_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_base_reg  <= DEFAULT_BASE;
      pend_base_reg <= DEFAULT_BASE;
      pending_reg   <= 1'b0;
    end else begin
      if (vga_offset_sel) cur_base_reg <= vga_offset;
      if (cpu_base_we) begin
        pend_base_reg <= cpu_base_din;
        pending_reg   <= 1'b1;
      end else if (vga_offset_sel) begin
        pending_reg <= 1'b0;
      end
    end
  end

endmodule
